// File: rtl/prbs_gen_chk_if.sv
// Bundles the generator/checker control and data signals of prbs_gen_chk.
// The master side drives stimulus and received words; the slave side is the PRBS block.
interface prbs_gen_chk_if #(
    parameter int W     = 1,
    parameter int CNT_W = 16
);
    logic [1:0]       mode;
    logic             gen_en;
    logic             inj_err;
    logic [W-1:0]     gen_data;
    logic             gen_valid;
    logic             chk_valid;
    logic [W-1:0]     chk_data;
    logic             clr_cnt;
    logic             locked;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output mode, gen_en, inj_err, chk_valid, chk_data, clr_cnt,
        input  gen_data, gen_valid, locked, err_cnt
    );

    modport slave (
        input  mode, gen_en, inj_err, chk_valid, chk_data, clr_cnt,
        output gen_data, gen_valid, locked, err_cnt
    );
endinterface

// File: rtl/prbs_gen_chk.sv
// W-bit-per-clock PRBS7/15/23/31 generator with error injection, plus a
// self-synchronising checker that locks to the same sequence and counts bit errors.
module prbs_gen_chk #(
    parameter int W          = 1,
    parameter int CNT_W      = 16,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    prbs_gen_chk_if.slave bus
);
    localparam int SW    = 31;
    localparam int EW    = $clog2(W + 1);
    localparam int GW    = $clog2(LOCK_CNT + 1);
    localparam int BW    = $clog2(UNLOCK_CNT + 1);
    localparam int SUM_W = CNT_W + 1;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    logic [1:0]       mode_q;
    logic [SW-1:0]    gen_s;
    logic [W-1:0]     gen_data_q;
    logic             gen_valid_q;
    chk_state_t       state;
    logic [SW-1:0]    chk_h;
    logic [4:0]       fill;
    logic [GW-1:0]    good_cnt;
    logic [BW-1:0]    bad_cnt;
    logic             locked_q;
    logic [CNT_W-1:0] err_cnt_q;

    // Polynomial selection follows the registered mode so a change reseeds first.
    logic [4:0]    n_len;
    logic [4:0]    n_top;
    logic [4:0]    tap;
    logic [SW-1:0] mask;

    always_comb begin
        n_len = 5'd7;
        n_top = 5'd6;
        tap   = 5'd5;
        mask  = 31'h0000_007F;
        case (mode_q)
            2'b01: begin
                n_len = 5'd15; n_top = 5'd14; tap = 5'd13; mask = 31'h0000_7FFF;
            end
            2'b10: begin
                n_len = 5'd23; n_top = 5'd22; tap = 5'd17; mask = 31'h007F_FFFF;
            end
            2'b11: begin
                n_len = 5'd31; n_top = 5'd30; tap = 5'd27; mask = 31'h7FFF_FFFF;
            end
            default: ;
        endcase
    end

    // Generator: W LFSR steps per word, earliest bit lands in the MSB.
    logic [SW-1:0] g_s;
    logic [W-1:0]  g_word;
    logic          g_bit;
    logic [W-1:0]  inj_mask;

    // NOTE: blocking assignments to temporaries are correct here; this block
    // unrolls W sequential steps combinationally and holds no state.
    always_comb begin
        g_s    = gen_s;
        g_word = '0;
        g_bit  = 1'b0;
        for (int i = 0; i < W; i++) begin
            g_bit         = g_s[n_top];
            g_s           = ((g_s << 1) | SW'(g_bit ^ g_s[tap])) & mask;
            g_word[W-1-i] = g_bit;
        end
    end

    assign inj_mask = W'(bus.inj_err) << (W - 1);

    // Checker: e = rx ^ h[N-1] ^ h[tap], history takes the raw received bit.
    logic [SW-1:0] c_h;
    logic [4:0]    c_fill;
    logic [W-1:0]  e_vec;
    logic [EW-1:0] n_err;
    logic          c_rx;

    always_comb begin
        c_h    = chk_h;
        c_fill = fill;
        e_vec  = '0;
        n_err  = '0;
        c_rx   = 1'b0;
        for (int i = 0; i < W; i++) begin
            c_rx = bus.chk_data[W-1-i];
            if (c_fill == n_len) begin
                e_vec[i] = c_rx ^ c_h[n_top] ^ c_h[tap];
            end else begin
                c_fill = c_fill + 5'd1;
            end
            c_h   = ((c_h << 1) | SW'(c_rx)) & mask;
            n_err = n_err + EW'(e_vec[i]);
        end
    end

    // A word only counts as clean if every bit was really checked and the
    // history is not all-zero, so a stuck-0 line can never lock.
    logic             word_err;
    logic             word_clean;
    logic [SUM_W-1:0] err_sum;
    logic [CNT_W-1:0] err_sat;

    assign word_err   = |e_vec;
    assign word_clean = (fill == n_len) && !word_err && (c_h != '0);
    assign err_sum    = {1'b0, err_cnt_q} + SUM_W'(n_err);
    assign err_sat    = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q      <= bus.mode;
            gen_s       <= SW'(1);
            gen_data_q  <= '0;
            gen_valid_q <= 1'b0;
            state       <= SEARCH;
            chk_h       <= '0;
            fill        <= '0;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            locked_q    <= 1'b0;
            err_cnt_q   <= '0;
        end else if (bus.mode != mode_q) begin
            mode_q      <= bus.mode;
            gen_s       <= SW'(1);
            gen_valid_q <= 1'b0;
            state       <= SEARCH;
            chk_h       <= '0;
            fill        <= '0;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            locked_q    <= 1'b0;
            if (bus.clr_cnt) err_cnt_q <= '0;
        end else begin
            gen_valid_q <= bus.gen_en;
            if (bus.gen_en) begin
                gen_s      <= g_s;
                gen_data_q <= g_word ^ inj_mask;
            end

            if (bus.chk_valid) begin
                chk_h <= c_h;
                fill  <= c_fill;
                case (state)
                    SEARCH: begin
                        if (!word_clean) begin
                            good_cnt <= '0;
                        end else if (good_cnt == GW'(LOCK_CNT - 1)) begin
                            state    <= LOCKED;
                            locked_q <= 1'b1;
                            good_cnt <= '0;
                            bad_cnt  <= '0;
                        end else begin
                            good_cnt <= good_cnt + GW'(1);
                        end
                    end
                    LOCKED: begin
                        err_cnt_q <= err_sat;
                        if (!word_err) begin
                            bad_cnt <= '0;
                        end else if (bad_cnt == BW'(UNLOCK_CNT - 1)) begin
                            state    <= SEARCH;
                            locked_q <= 1'b0;
                            bad_cnt  <= '0;
                            good_cnt <= '0;
                        end else begin
                            bad_cnt <= bad_cnt + BW'(1);
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end

            // Placed last so a clear overrides an increment in the same cycle.
            if (bus.clr_cnt) err_cnt_q <= '0;
        end
    end

    assign bus.gen_data  = gen_data_q;
    assign bus.gen_valid = gen_valid_q;
    assign bus.locked    = locked_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_prbs_gen_chk.sv
// Directed bench for prbs_gen_chk: W=1 and W=8 instances with 16-bit counters,
// plus a W=8 instance with a 4-bit counter for saturation.
module tb_prbs_gen_chk;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_eval = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    prbs_gen_chk_if #(.W(1), .CNT_W(16)) b1 ();
    prbs_gen_chk_if #(.W(8), .CNT_W(16)) b8 ();
    prbs_gen_chk_if #(.W(8), .CNT_W(4))  bs ();

    logic       loop1 = 1'b0;
    logic       loop8 = 1'b0;
    logic       loops = 1'b0;
    logic       inv8  = 1'b0;
    logic       cv8   = 1'b0;
    logic [7:0] cd8   = 8'h00;

    assign b1.chk_valid = loop1 & b1.gen_valid;
    assign b1.chk_data  = b1.gen_data;
    assign b8.chk_valid = loop8 ? b8.gen_valid : cv8;
    assign b8.chk_data  = loop8 ? (inv8 ? ~b8.gen_data : b8.gen_data) : cd8;
    assign bs.chk_valid = loops & bs.gen_valid;
    assign bs.chk_data  = bs.gen_data;

    prbs_gen_chk #(.W(1), .CNT_W(16), .LOCK_CNT(8), .UNLOCK_CNT(4)) u_w1 (
        .clk(clk), .rst_n(rst_n), .bus(b1));
    prbs_gen_chk #(.W(8), .CNT_W(16), .LOCK_CNT(8), .UNLOCK_CNT(4)) u_w8 (
        .clk(clk), .rst_n(rst_n), .bus(b8));
    prbs_gen_chk #(.W(8), .CNT_W(4), .LOCK_CNT(8), .UNLOCK_CNT(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(bs));

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset(input string tag, input int cycles);
        rst_n = 1'b0;
        tick(cycles);
        n_eval++;
        if ({b1.gen_data, b1.gen_valid, b1.locked, b1.err_cnt} !== 19'h0) begin
            n_fail++;
            $display("FAIL %s_reset_w1: got %0h expected 0", tag,
                     {b1.gen_data, b1.gen_valid, b1.locked, b1.err_cnt});
        end
        n_eval++;
        if ({b8.gen_data, b8.gen_valid, b8.locked, b8.err_cnt} !== 26'h0) begin
            n_fail++;
            $display("FAIL %s_reset_w8: got %0h expected 0", tag,
                     {b8.gen_data, b8.gen_valid, b8.locked, b8.err_cnt});
        end
        n_eval++;
        if ({bs.gen_data, bs.gen_valid, bs.locked, bs.err_cnt} !== 14'h0) begin
            n_fail++;
            $display("FAIL %s_reset_sat: got %0h expected 0", tag,
                     {bs.gen_data, bs.gen_valid, bs.locked, bs.err_cnt});
        end
        rst_n = 1'b1;
    endtask

    // PRBS31 from seed 1: bits 1..30 are 0, bit 31 is 1, bit 32 is 0.
    task automatic test_prbs31_seq();
        logic [30:0] bits = '0;
        b1.gen_en = 1'b1;
        tick(1);
        n_eval++;
        if (b1.gen_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL prbs31_valid: got %b expected 1", b1.gen_valid);
        end
        bits = {bits[29:0], b1.gen_data[0]};
        for (int k = 2; k <= 31; k++) begin
            tick(1);
            bits = {bits[29:0], b1.gen_data[0]};
        end
        n_eval++;
        if (bits !== 31'd1) begin
            n_fail++;
            $display("FAIL prbs31_bits_1_31: got %b expected %b", bits, 31'd1);
        end
        tick(1);
        n_eval++;
        if (b1.gen_data[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL prbs31_bit32: got %b expected 0", b1.gen_data[0]);
        end
    endtask

    // PRBS7: switching mode reseeds, sequence 0000001 000001100..., period 127, 64 ones.
    task automatic test_prbs7_period();
        logic seq [1:134];
        int   ones;
        logic [6:0] head;
        logic [6:0] wrap;
        logic [8:0] mid;
        b1.mode = 2'b00;
        tick(1);
        n_eval++;
        if (b1.gen_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mode_change_valid: got %b expected 0", b1.gen_valid);
        end
        for (int k = 1; k <= 134; k++) begin
            tick(1);
            seq[k] = b1.gen_data[0];
        end
        ones = 0;
        for (int k = 1; k <= 127; k++) ones += int'(seq[k]);
        head = '0;
        wrap = '0;
        mid  = '0;
        for (int k = 1; k <= 7; k++) begin
            head = {head[5:0], seq[k]};
            wrap = {wrap[5:0], seq[k+127]};
        end
        for (int k = 8; k <= 16; k++) mid = {mid[7:0], seq[k]};
        n_eval++;
        if (head !== 7'b0000001) begin
            n_fail++;
            $display("FAIL prbs7_head: got %b expected 0000001", head);
        end
        n_eval++;
        if (mid !== 9'b000001100) begin
            n_fail++;
            $display("FAIL prbs7_bits_8_16: got %b expected 000001100", mid);
        end
        n_eval++;
        if (ones !== 64) begin
            n_fail++;
            $display("FAIL prbs7_ones_per_period: got %0d expected 64", ones);
        end
        n_eval++;
        if (wrap !== 7'b0000001) begin
            n_fail++;
            $display("FAIL prbs7_period_wrap: got %b expected 0000001", wrap);
        end
    endtask

    // W=8 loopback: word 1 fills the history, words 2..9 clean, lock at edge 10.
    task automatic test_lock_w8();
        loop8     = 1'b1;
        b8.gen_en = 1'b1;
        tick(1);
        n_eval++;
        if ({b8.gen_valid, b8.gen_data} !== 9'h102) begin
            n_fail++;
            $display("FAIL w8_word1: got %h expected 102", {b8.gen_valid, b8.gen_data});
        end
        tick(1);
        n_eval++;
        if (b8.gen_data !== 8'h0C) begin
            n_fail++;
            $display("FAIL w8_word2: got %h expected 0c", b8.gen_data);
        end
        tick(7);
        n_eval++;
        if (b8.locked !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_early: got %b expected 0", b8.locked);
        end
        tick(1);
        n_eval++;
        if (b8.locked !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_edge10: got %b expected 1", b8.locked);
        end
        tick(990);
        n_eval++;
        if ({b8.locked, b8.err_cnt} !== 17'h10000) begin
            n_fail++;
            $display("FAIL clean_1000_words: got %h expected 10000", {b8.locked, b8.err_cnt});
        end
    endtask

    // One injected bit plus its two tap echoes fall inside the same 8-bit word.
    task automatic test_inj_err();
        for (int p = 1; p <= 2; p++) begin
            b8.inj_err = 1'b1;
            tick(1);
            b8.inj_err = 1'b0;
            tick(4);
            n_eval++;
            if ({b8.locked, b8.err_cnt} !== {1'b1, 16'(3 * p)}) begin
                n_fail++;
                $display("FAIL inj_err_pulse%0d: got %h expected %h", p,
                         {b8.locked, b8.err_cnt}, {1'b1, 16'(3 * p)});
            end
        end
    endtask

    // Stuck-0 never locks; after locking, an inverted stream errors 7,8,8,8 bits.
    task automatic test_stuck_and_unlock();
        logic ever_locked = 1'b0;
        b8.gen_en  = 1'b0;
        loop8      = 1'b0;
        cv8        = 1'b1;
        cd8        = 8'h00;
        b8.mode    = 2'b01;
        b8.clr_cnt = 1'b1;
        tick(1);
        b8.mode    = 2'b00;
        b8.clr_cnt = 1'b0;
        tick(1);
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (b8.locked === 1'b1) ever_locked = 1'b1;
        end
        n_eval++;
        if ({ever_locked, b8.err_cnt} !== 17'h0) begin
            n_fail++;
            $display("FAIL stuck0_no_lock: got %h expected 0", {ever_locked, b8.err_cnt});
        end
        b8.gen_en = 1'b1;
        loop8     = 1'b1;
        tick(30);
        n_eval++;
        if ({b8.locked, b8.err_cnt} !== 17'h10000) begin
            n_fail++;
            $display("FAIL relock: got %h expected 10000", {b8.locked, b8.err_cnt});
        end
        inv8 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            n_eval++;
            if (b8.locked !== 1'b1) begin
                n_fail++;
                $display("FAIL unlock_early_word%0d: got %b expected 1", i, b8.locked);
            end
        end
        n_eval++;
        if (b8.err_cnt !== 16'd23) begin
            n_fail++;
            $display("FAIL inverted_err_3words: got %0d expected 23", b8.err_cnt);
        end
        tick(1);
        n_eval++;
        if ({b8.locked, b8.err_cnt} !== {1'b0, 16'd31}) begin
            n_fail++;
            $display("FAIL unlock_word4: got %h expected %h", {b8.locked, b8.err_cnt},
                     {1'b0, 16'd31});
        end
        inv8 = 1'b0;
    endtask

    task automatic test_saturation();
        loops     = 1'b1;
        bs.gen_en = 1'b1;
        tick(20);
        n_eval++;
        if ({bs.locked, bs.err_cnt} !== 5'h10) begin
            n_fail++;
            $display("FAIL sat_lock: got %h expected 10", {bs.locked, bs.err_cnt});
        end
        for (int p = 0; p < 6; p++) begin
            bs.inj_err = 1'b1;
            tick(1);
            bs.inj_err = 1'b0;
            tick(3);
        end
        n_eval++;
        if ({bs.locked, bs.err_cnt} !== 5'h1F) begin
            n_fail++;
            $display("FAIL sat_at_15: got %h expected 1f", {bs.locked, bs.err_cnt});
        end
        bs.clr_cnt = 1'b1;
        tick(1);
        bs.clr_cnt = 1'b0;
        n_eval++;
        if (bs.err_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL clr_plain: got %0d expected 0", bs.err_cnt);
        end
        bs.inj_err = 1'b1;
        tick(1);
        bs.inj_err = 1'b0;
        bs.clr_cnt = 1'b1;
        tick(1);
        bs.clr_cnt = 1'b0;
        tick(3);
        n_eval++;
        if ({bs.locked, bs.err_cnt} !== 5'h10) begin
            n_fail++;
            $display("FAIL clr_wins: got %h expected 10", {bs.locked, bs.err_cnt});
        end
        bs.inj_err = 1'b1;
        tick(1);
        bs.inj_err = 1'b0;
        tick(3);
        n_eval++;
        if (bs.err_cnt !== 4'd3) begin
            n_fail++;
            $display("FAIL count_after_clr: got %0d expected 3", bs.err_cnt);
        end
    endtask

    task automatic test_mode_change();
        logic [30:0] bits = '0;
        loop1 = 1'b1;
        tick(40);
        n_eval++;
        if (b1.locked !== 1'b1) begin
            n_fail++;
            $display("FAIL w1_lock: got %b expected 1", b1.locked);
        end
        b1.mode = 2'b11;
        tick(1);
        n_eval++;
        if ({b1.locked, b1.gen_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL mode_change_drop: got %b expected 00", {b1.locked, b1.gen_valid});
        end
        for (int k = 1; k <= 31; k++) begin
            tick(1);
            bits = {bits[29:0], b1.gen_data[0]};
        end
        n_eval++;
        if (bits !== 31'd1) begin
            n_fail++;
            $display("FAIL reseed_prbs31: got %b expected %b", bits, 31'd1);
        end
    endtask

    initial begin
        b1.mode = 2'b11; b1.gen_en = 1'b0; b1.inj_err = 1'b0; b1.clr_cnt = 1'b0;
        b8.mode = 2'b00; b8.gen_en = 1'b0; b8.inj_err = 1'b0; b8.clr_cnt = 1'b0;
        bs.mode = 2'b00; bs.gen_en = 1'b0; bs.inj_err = 1'b0; bs.clr_cnt = 1'b0;
        test_reset("init", 3);
        test_prbs31_seq();
        test_prbs7_period();
        test_lock_w8();
        test_inj_err();
        test_stuck_and_unlock();
        test_saturation();
        test_mode_change();
        test_reset("mid", 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end
endmodule
